// File: rtl/moore_seq_det_param.sv
// Moore serial sequence detector with a runtime-loadable pattern (1..MAX_LEN bits) and overlap/non-overlap modes.
// Define MOORE_SEQ_DET_CNT_EN to build in the saturating match counter (match_cnt, cnt_sat, cnt_clr).
module moore_seq_det_param #(
    parameter int                 MAX_LEN = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1010),
    parameter int                 DEF_LEN = 4,
    parameter int                 CNT_W   = 8,
    parameter int                 LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LW-1:0]      len_in,
    input  logic               ovl_in,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        MATCH = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [MAX_LEN-1:0] pat_reg, pat_next;
    logic [LW-1:0]      len_reg, len_next;
    logic               ovl_reg, ovl_next;
    logic [MAX_LEN-1:0] hist_reg, hist_next;
    logic [LW-1:0]      fill_reg, fill_next;

    logic [MAX_LEN-1:0] hist_acc;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill_inc;
    logic [LW-1:0]      len_clamped;
    logic               pat_eq;
    logic               hit;
    logic               match_entry;

    // Only the low len bits of the history take part in the compare.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (len_reg > LW'(gi));
        end
    endgenerate

    assign hist_acc    = {hist_reg[MAX_LEN-2:0], din};
    assign fill_inc    = (fill_reg >= len_reg) ? len_reg : fill_reg + LW'(1);
    assign pat_eq      = (((hist_acc ^ pat_reg) & len_mask) == '0);
    assign hit         = (fill_inc == len_reg) && pat_eq;
    assign match_entry = !pat_load && din_valid && hit;

    always_comb begin
        len_clamped = len_in;
        if (len_in == '0)
            len_clamped = LW'(1);
        else if (len_in > LW'(MAX_LEN))
            len_clamped = LW'(MAX_LEN);
    end

    always_comb begin
        state_next = state_reg;
        pat_next   = pat_reg;
        len_next   = len_reg;
        ovl_next   = ovl_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        if (pat_load) begin
            pat_next   = pat_in;
            len_next   = len_clamped;
            ovl_next   = ovl_in;
            hist_next  = '0;
            fill_next  = '0;
            state_next = FILL;
        end else if (din_valid) begin
            hist_next = hist_acc;
            fill_next = fill_inc;
            if (hit) begin
                state_next = MATCH;
                // Non-overlapping mode demands len fresh bits before the next hit.
                if (!ovl_reg)
                    fill_next = '0;
            end else if (fill_inc == len_reg) begin
                state_next = ARMED;
            end else begin
                state_next = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FILL;
            pat_reg   <= DEF_PAT;
            len_reg   <= LW'(DEF_LEN);
            ovl_reg   <= 1'b1;
            hist_reg  <= '0;
            fill_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pat_reg   <= pat_next;
            len_reg   <= len_next;
            ovl_reg   <= ovl_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
        end
    end

    assign y = (state_reg == MATCH);

`ifdef MOORE_SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             unused_bits;

    // Clear beats a simultaneous MATCH entry; the count sticks at all ones.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr)
            cnt_next = '0;
        else if (match_entry && !(&cnt_reg))
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

    assign match_cnt   = cnt_reg;
    assign cnt_sat     = &cnt_reg;
    assign unused_bits = hist_reg[MAX_LEN-1];
`else
    logic [2:0] unused_bits;

    assign match_cnt   = '0;
    assign cnt_sat     = 1'b0;
    assign unused_bits = {hist_reg[MAX_LEN-1], cnt_clr, match_entry};
`endif

endmodule
